// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI-to-RAM command bridge.
package spi_mem_pkg;

    localparam int BYTE_W    = 8;
    localparam int CMD_W_BIT = 7;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WDATA,
        RFETCH,
        RDATA
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous pin, plus a third flop for
// rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_reg <= RST_VAL;
            sync_reg <= RST_VAL;
            prev_reg <= RST_VAL;
        end else begin
            meta_reg <= din;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign sync = sync_reg;
    assign rise = sync_reg & ~prev_reg;
    assign fall = ~sync_reg & prev_reg;

endmodule

// File: rtl/spi_mem_bridge.sv
// SPI mode-0 slave that turns command/data frames into RAM write and read
// strobes, with auto-incrementing bursts and a prefetching read path.
module spi_mem_bridge
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              abort
);

    localparam int SCLK_I = 0;
    localparam int CS_I   = 1;
    localparam int MOSI_I = 2;
    localparam logic [1:0] RD_LAT_C = 2'(RD_LAT);

    logic [2:0] pin_vec;
    logic [2:0] sync_vec;
    logic [2:0] rise_vec;
    logic [2:0] fall_vec;

    assign pin_vec = {mosi, cs_n, sclk};

    // chip select idles high so reset must not look like a selected frame
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            spi_sync_edge #(
                .RST_VAL(1'(gi == CS_I))
            ) u_sync (
                .clk  (clk),
                .rst  (rst),
                .din  (pin_vec[gi]),
                .sync (sync_vec[gi]),
                .rise (rise_vec[gi]),
                .fall (fall_vec[gi])
            );
        end
    endgenerate

    logic sclk_rise;
    logic sclk_fall;
    logic cs_sync;
    logic mosi_sync;
    logic sync_unused;

    assign sclk_rise   = rise_vec[SCLK_I];
    assign sclk_fall   = fall_vec[SCLK_I];
    assign cs_sync     = sync_vec[CS_I];
    assign mosi_sync   = sync_vec[MOSI_I];
    assign sync_unused = &{1'b0, sync_vec[SCLK_I], rise_vec[2:1], fall_vec[2:1]};

    state_t              state_reg,     state_next;
    logic [2:0]          bit_cnt_reg,   bit_cnt_next;
    logic [BYTE_W-1:0]   rx_reg,        rx_next;
    logic [BYTE_W-1:0]   tx_reg,        tx_next;
    logic [ADDR_W-1:0]   addr_reg,      addr_next;
    logic [ADDR_W-1:0]   mem_addr_reg,  mem_addr_next;
    logic [BYTE_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic                mem_we_reg,    mem_we_next;
    logic                mem_re_reg,    mem_re_next;
    logic                miso_reg,      miso_next;
    logic                abort_reg,     abort_next;
    logic                rf_issued_reg, rf_issued_next;
    logic [1:0]          rf_cnt_reg,    rf_cnt_next;

    logic [BYTE_W-1:0]   rx_byte;
    logic                byte_done;

    assign rx_byte   = {rx_reg[BYTE_W-2:0], mosi_sync};
    assign byte_done = sclk_rise && (bit_cnt_reg == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            rx_reg        <= '0;
            tx_reg        <= '0;
            addr_reg      <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_we_reg    <= 1'b0;
            mem_re_reg    <= 1'b0;
            miso_reg      <= 1'b0;
            abort_reg     <= 1'b0;
            rf_issued_reg <= 1'b0;
            rf_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            rx_reg        <= rx_next;
            tx_reg        <= tx_next;
            addr_reg      <= addr_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            mem_we_reg    <= mem_we_next;
            mem_re_reg    <= mem_re_next;
            miso_reg      <= miso_next;
            abort_reg     <= abort_next;
            rf_issued_reg <= rf_issued_next;
            rf_cnt_reg    <= rf_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        rx_next        = rx_reg;
        tx_next        = tx_reg;
        addr_next      = addr_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        mem_we_next    = 1'b0;
        mem_re_next    = 1'b0;
        miso_next      = miso_reg;
        abort_next     = 1'b0;
        rf_issued_next = rf_issued_reg;
        rf_cnt_next    = rf_cnt_reg;

        // every selected rise is counted, so a partial byte is visible in any state
        if (state_reg != IDLE && sclk_rise) begin
            rx_next      = rx_byte;
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end

        case (state_reg)
            IDLE: begin
                miso_next = 1'b0;
                if (!cs_sync) begin
                    state_next   = CMD;
                    bit_cnt_next = '0;
                    rx_next      = '0;
                end
            end
            CMD: begin
                if (byte_done) begin
                    addr_next      = rx_byte[ADDR_W-1:0];
                    rf_issued_next = 1'b0;
                    state_next     = rx_byte[CMD_W_BIT] ? WDATA : RFETCH;
                end
            end
            WDATA: begin
                if (byte_done) begin
                    mem_wdata_next = rx_byte;
                    mem_addr_next  = addr_reg;
                    mem_we_next    = 1'b1;
                    addr_next      = addr_reg + ADDR_W'(1);
                end
            end
            RFETCH: begin
                if (!rf_issued_reg) begin
                    mem_addr_next  = addr_reg;
                    mem_re_next    = 1'b1;
                    rf_issued_next = 1'b1;
                    rf_cnt_next    = '0;
                end else if (rf_cnt_reg == RD_LAT_C) begin
                    tx_next    = mem_rdata;
                    miso_next  = mem_rdata[BYTE_W-1];
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = RDATA;
                end else begin
                    rf_cnt_next = rf_cnt_reg + 2'd1;
                end
            end
            RDATA: begin
                // the fall that trails the 8th rise belongs to the previous byte
                if (sclk_fall && bit_cnt_reg != 3'd0) begin
                    tx_next   = {tx_reg[BYTE_W-2:0], 1'b0};
                    miso_next = tx_reg[BYTE_W-2];
                end
                if (byte_done) begin
                    rf_issued_next = 1'b0;
                    state_next     = RFETCH;
                end
            end
            default: state_next = IDLE;
        endcase

        // deselect wins over everything except a write already committed this cycle
        if (state_reg != IDLE && cs_sync) begin
            state_next  = IDLE;
            miso_next   = 1'b0;
            mem_re_next = 1'b0;
            abort_next  = (bit_cnt_next != 3'd0);
        end
    end

    assign miso      = miso_reg;
    assign miso_oe   = (state_reg != IDLE);
    assign busy      = (state_reg != IDLE);
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_we    = mem_we_reg;
    assign mem_re    = mem_re_reg;
    assign abort     = abort_reg;

endmodule

// File: tb/tb_spi_mem_bridge.sv
// Directed bench for spi_mem_bridge: bit-banged SPI master, RAM model with
// one-cycle read latency, and scoreboards for write/read strobes.
module tb_spi_mem_bridge;

    localparam int ADDR_W = 5;
    localparam int RD_LAT = 1;
    localparam int HALF   = 10;

    logic              clk  = 1'b0;
    logic              rst  = 1'b1;
    logic              sclk = 1'b0;
    logic              cs_n = 1'b1;
    logic              mosi = 1'b0;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [7:0]        mem_rdata = 8'h00;
    logic              busy;
    logic              abort;

    always #5 clk = ~clk;

    spi_mem_bridge #(
        .ADDR_W (ADDR_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sclk      (sclk),
        .cs_n      (cs_n),
        .mosi      (mosi),
        .miso      (miso),
        .miso_oe   (miso_oe),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .abort     (abort)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         abort_cnt = 0;
    logic [7:0] ram [32];
    logic [7:0] exp_wr_addr [$];
    logic [7:0] exp_wr_data [$];
    logic [7:0] exp_rd_addr [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // RAM model: data is presented only in the cycle RD_LAT after mem_re
    task automatic monitor();
        logic              rd_pend = 1'b0;
        logic [ADDR_W-1:0] rd_addr = '0;
        logic [7:0]        ea;
        logic [7:0]        ed;
        forever begin
            @(negedge clk);
            mem_rdata = rd_pend ? ram[rd_addr] : 8'hEE;
            rd_pend   = 1'b0;
            if (mem_we || mem_re)
                chk("we_re_exclusive", {31'b0, mem_we & mem_re}, 32'd0);
            if (mem_we) begin
                chk("we_expected", {31'b0, exp_wr_addr.size() != 0}, 32'd1);
                if (exp_wr_addr.size() != 0) begin
                    ea = exp_wr_addr.pop_front();
                    ed = exp_wr_data.pop_front();
                    chk("wr_addr", {27'b0, mem_addr}, {24'b0, ea});
                    chk("wr_data", {24'b0, mem_wdata}, {24'b0, ed});
                end
                ram[mem_addr] = mem_wdata;
            end
            if (mem_re) begin
                chk("re_expected", {31'b0, exp_rd_addr.size() != 0}, 32'd1);
                if (exp_rd_addr.size() != 0) begin
                    ea = exp_rd_addr.pop_front();
                    chk("rd_addr", {27'b0, mem_addr}, {24'b0, ea});
                end
                rd_pend = 1'b1;
                rd_addr = mem_addr;
            end
            if (abort)
                abort_cnt++;
        end
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 7; i >= 8 - n; i--) begin
            mosi = tx[i];
            wait_clks(HALF);
            sclk  = 1'b1;
            rx[i] = miso;
            wait_clks(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic select();
        cs_n = 1'b0;
        wait_clks(6);
    endtask

    task automatic deselect();
        wait_clks(4);
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_miso_oe"}, {31'b0, miso_oe}, 32'd0);
        chk({tag, "_wr_left"}, exp_wr_addr.size(), 32'd0);
        chk({tag, "_rd_left"}, exp_rd_addr.size(), 32'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},      {31'b0, busy},      32'd0);
        chk({tag, "_miso_oe"},   {31'b0, miso_oe},   32'd0);
        chk({tag, "_miso"},      {31'b0, miso},      32'd0);
        chk({tag, "_mem_we"},    {31'b0, mem_we},    32'd0);
        chk({tag, "_mem_re"},    {31'b0, mem_re},    32'd0);
        chk({tag, "_abort"},     {31'b0, abort},     32'd0);
        chk({tag, "_mem_addr"},  {27'b0, mem_addr},  32'd0);
        chk({tag, "_mem_wdata"}, {24'b0, mem_wdata}, 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        int         a0;

        for (int i = 0; i < 32; i++) ram[i] = 8'h00;
        fork
            monitor();
        join_none

        wait_clks(3);
        chk_all_zero("reset");
        rst = 1'b0;
        wait_clks(3);

        // single write
        exp_wr_addr.push_back(8'h05); exp_wr_data.push_back(8'hAA);
        a0 = abort_cnt;
        select();
        spi_bits(8'h85, 8, rx);
        chk("wr1_busy", {31'b0, busy}, 32'd1);
        chk("wr1_miso_oe", {31'b0, miso_oe}, 32'd1);
        spi_bits(8'hAA, 8, rx);
        deselect();
        chk_idle("wr1");
        chk("wr1_no_abort", abort_cnt - a0, 32'd0);
        $display("write 0x85/0xAA done");

        // single read
        ram[5] = 8'h3C;
        exp_rd_addr.push_back(8'h05); exp_rd_addr.push_back(8'h06);
        select();
        spi_bits(8'h05, 8, rx);
        spi_bits(8'h00, 8, rx);
        chk("rd1_byte", {24'b0, rx}, 32'h3C);
        deselect();
        chk_idle("rd1");
        chk("rd1_miso_idle", {31'b0, miso}, 32'd0);
        $display("read 0x05 returned %02h", rx);

        // write burst across the top of memory
        exp_wr_addr.push_back(8'h1E); exp_wr_data.push_back(8'h11);
        exp_wr_addr.push_back(8'h1F); exp_wr_data.push_back(8'h22);
        exp_wr_addr.push_back(8'h00); exp_wr_data.push_back(8'h33);
        select();
        spi_bits(8'h9E, 8, rx);
        spi_bits(8'h11, 8, rx);
        spi_bits(8'h22, 8, rx);
        spi_bits(8'h33, 8, rx);
        deselect();
        chk_idle("wrb");
        $display("write burst 0x9E/11/22/33 done");

        // read burst across the top of memory, back-to-back bytes
        ram[31] = 8'hA5;
        ram[0]  = 8'h5A;
        exp_rd_addr.push_back(8'h1F); exp_rd_addr.push_back(8'h00); exp_rd_addr.push_back(8'h01);
        select();
        spi_bits(8'h1F, 8, rx);
        spi_bits(8'h00, 8, rx);
        chk("rdb_byte0", {24'b0, rx}, 32'hA5);
        spi_bits(8'h00, 8, rx);
        chk("rdb_byte1", {24'b0, rx}, 32'h5A);
        deselect();
        chk_idle("rdb");
        $display("read burst 0x1F done");

        // partial data byte then deselect
        a0 = abort_cnt;
        select();
        spi_bits(8'h81, 8, rx);
        spi_bits(8'hFF, 5, rx);
        deselect();
        chk("abort_pulses", abort_cnt - a0, 32'd1);
        chk_idle("abort");
        $display("abort after 5 bits done");

        // reset during the 4th data bit of a write
        a0 = abort_cnt;
        select();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'h77, 3, rx);
        mosi = 1'b1;
        wait_clks(HALF);
        sclk = 1'b1;
        wait_clks(2);
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        sclk = 1'b0;
        cs_n = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(3);
        chk("midrst_no_abort", abort_cnt - a0, 32'd0);
        $display("reset mid-write done");

        exp_wr_addr.push_back(8'h03); exp_wr_data.push_back(8'h77);
        select();
        spi_bits(8'h83, 8, rx);
        spi_bits(8'h77, 8, rx);
        deselect();
        chk_idle("wr2");
        chk("wr2_ram", {24'b0, ram[3]}, 32'h77);
        $display("write 0x83/0x77 done");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
